cell_painter: RTL and testbench

- Display-side consumer of the map scanner's per-cell change requests (diff, x, y, obj_code).
- For each accepted request, paints one CELL_PX x CELL_PX tile on the 320x240 TFT over an 8-bit 8080-style write bus: CASET, PASET, RAMWR, then RGB565 pixels.
- Returns a one-cycle cmd_done pulse so the scanner can resume its sweep.

---
 rtl/cell_painter_pkg.sv | 69 ++++++
 rtl/cell_painter_lcd_byte_writer.sv | 42 ++++
 rtl/cell_painter.sv | 172 +++++++++++++++++
 tb/tb_cell_painter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cell_painter_pkg.sv
// Shared constants, types and helpers for the cell painter: tile geometry,
// object codes, RGB565 palette, panel opcodes and the sequencer state set.
package cell_painter_pkg;

  localparam int unsigned CELL_PX = 20;
  localparam int unsigned GRID_W  = 16;
  localparam int unsigned GRID_H  = 12;
  localparam int unsigned COORD_W = 9;
  localparam int unsigned PIX_W   = 9;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned RGB_W   = 16;

  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(CELL_PX * CELL_PX - 1);

  localparam logic [2:0] OBJ_EMPTY  = 3'd0;
  localparam logic [2:0] OBJ_BODY   = 3'd1;
  localparam logic [2:0] OBJ_HEAD   = 3'd2;
  localparam logic [2:0] OBJ_APPLE  = 3'd3;
  localparam logic [2:0] OBJ_BORDER = 3'd4;

  localparam logic [RGB_W-1:0] RGB_EMPTY  = 16'h0000;
  localparam logic [RGB_W-1:0] RGB_BODY   = 16'h07E0;
  localparam logic [RGB_W-1:0] RGB_HEAD   = 16'hFFE0;
  localparam logic [RGB_W-1:0] RGB_APPLE  = 16'hF800;
  localparam logic [RGB_W-1:0] RGB_BORDER = 16'h001F;
  localparam logic [RGB_W-1:0] RGB_DEBUG  = 16'hF81F;

  localparam logic [BYTE_W-1:0] CMD_CASET = 8'h2A;
  localparam logic [BYTE_W-1:0] CMD_PASET = 8'h2B;
  localparam logic [BYTE_W-1:0] CMD_RAMWR = 8'h2C;

  typedef enum logic [2:0] {
    IDLE,
    CASET,
    PASET,
    RAMWR,
    PIXELS,
    DONE,
    HOLD
  } state_t;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic [2:0] obj;
  } cell_req_t;

  // Tile colour for an object code; unknown codes render magenta.
  function automatic logic [RGB_W-1:0] obj_colour(input logic [2:0] obj);
    case (obj)
      OBJ_EMPTY:  return RGB_EMPTY;
      OBJ_BODY:   return RGB_BODY;
      OBJ_HEAD:   return RGB_HEAD;
      OBJ_APPLE:  return RGB_APPLE;
      OBJ_BORDER: return RGB_BORDER;
      default:    return RGB_DEBUG;
    endcase
  endfunction

  // Window argument bytes in order: start hi, start lo, end hi, end lo.
  function automatic logic [BYTE_W-1:0] coord_byte(input logic [COORD_W-1:0] c0,
                                                   input logic [COORD_W-1:0] c1,
                                                   input logic [1:0]         sel);
    logic [15:0] w;
    w = sel[1] ? 16'(c1) : 16'(c0);
    return sel[0] ? w[7:0] : w[15:8];
  endfunction

endpackage

// File: rtl/cell_painter_lcd_byte_writer.sv
// Two-phase 8080 byte writer: strobe low with the byte, then strobe high
// with the byte held; byte_done marks the release phase.
module cell_painter_lcd_byte_writer
  import cell_painter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dcx,
  input  logic [BYTE_W-1:0] data,
  output logic              lcd_wr_n,
  output logic              lcd_dcx,
  output logic [BYTE_W-1:0] lcd_data,
  output logic              byte_done
);

  logic phase0;

  // A start may land in the release phase so bytes stream back to back.
  always_ff @(posedge clk) begin
    if (rst) begin
      lcd_wr_n  <= 1'b1;
      lcd_dcx   <= 1'b1;
      lcd_data  <= '0;
      byte_done <= 1'b0;
      phase0    <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      if (start) begin
        lcd_wr_n <= 1'b0;
        lcd_dcx  <= dcx;
        lcd_data <= data;
        phase0   <= 1'b1;
      end else if (phase0) begin
        lcd_wr_n  <= 1'b1;
        byte_done <= 1'b1;
        phase0    <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cell_painter.sv
// Paints one tile per accepted cell-change request: window set-up commands
// followed by a solid RGB565 fill, then a one-cycle cmd_done handshake.
module cell_painter
  import cell_painter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              diff,
  input  logic [3:0]        x,
  input  logic [3:0]        y,
  input  logic [2:0]        obj_code,
  output logic              cmd_done,
  output logic              busy,
  output logic              lcd_wr_n,
  output logic              lcd_dcx,
  output logic [BYTE_W-1:0] lcd_data
);

  state_t            state, state_n;
  cell_req_t         req, req_n;
  logic [2:0]        sub, sub_n;
  logic [PIX_W-1:0]  pix, pix_n;
  logic              pix_lo, pix_lo_n;
  logic              busy_n, cmd_done_n;

  logic              start_c;
  logic              dcx_c;
  logic [BYTE_W-1:0] data_c;
  logic              byte_done;

  logic [COORD_W-1:0] x0, x1, y0, y1;
  logic [RGB_W-1:0]   colour;

  assign x0     = COORD_W'(req.x) * COORD_W'(CELL_PX);
  assign x1     = x0 + COORD_W'(CELL_PX - 1);
  assign y0     = COORD_W'(req.y) * COORD_W'(CELL_PX);
  assign y1     = y0 + COORD_W'(CELL_PX - 1);
  assign colour = obj_colour(req.obj);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      req      <= '0;
      sub      <= '0;
      pix      <= '0;
      pix_lo   <= 1'b0;
      busy     <= 1'b0;
      cmd_done <= 1'b0;
    end else begin
      state    <= state_n;
      req      <= req_n;
      sub      <= sub_n;
      pix      <= pix_n;
      pix_lo   <= pix_lo_n;
      busy     <= busy_n;
      cmd_done <= cmd_done_n;
    end
  end

  // Byte sequencer: each state issues its next byte on the writer's byte_done.
  always_comb begin
    state_n    = state;
    req_n      = req;
    sub_n      = sub;
    pix_n      = pix;
    pix_lo_n   = pix_lo;
    busy_n     = busy;
    cmd_done_n = 1'b0;
    start_c    = 1'b0;
    dcx_c      = 1'b1;
    data_c     = '0;

    unique case (state)
      IDLE: begin
        if (diff) begin
          req_n    = {x, y, obj_code};
          busy_n   = 1'b1;
          sub_n    = '0;
          pix_n    = '0;
          pix_lo_n = 1'b0;
          if (y >= 4'(GRID_H)) begin
            state_n    = DONE;
            cmd_done_n = 1'b1;
          end else begin
            state_n = CASET;
            start_c = 1'b1;
            dcx_c   = 1'b0;
            data_c  = CMD_CASET;
          end
        end
      end
      CASET: begin
        if (byte_done) begin
          start_c = 1'b1;
          if (sub == 3'd4) begin
            dcx_c   = 1'b0;
            data_c  = CMD_PASET;
            sub_n   = '0;
            state_n = PASET;
          end else begin
            data_c = coord_byte(x0, x1, sub[1:0]);
            sub_n  = sub + 3'd1;
          end
        end
      end
      PASET: begin
        if (byte_done) begin
          start_c = 1'b1;
          if (sub == 3'd4) begin
            dcx_c   = 1'b0;
            data_c  = CMD_RAMWR;
            sub_n   = '0;
            state_n = RAMWR;
          end else begin
            data_c = coord_byte(y0, y1, sub[1:0]);
            sub_n  = sub + 3'd1;
          end
        end
      end
      RAMWR: begin
        if (byte_done) begin
          start_c  = 1'b1;
          data_c   = colour[15:8];
          pix_n    = '0;
          pix_lo_n = 1'b0;
          state_n  = PIXELS;
        end
      end
      PIXELS: begin
        // pix_lo tells whether the byte now on the bus is the pixel's low half.
        if (byte_done) begin
          if (!pix_lo) begin
            start_c  = 1'b1;
            data_c   = colour[7:0];
            pix_lo_n = 1'b1;
          end else if (pix == PIX_LAST) begin
            state_n    = DONE;
            cmd_done_n = 1'b1;
          end else begin
            start_c  = 1'b1;
            data_c   = colour[15:8];
            pix_n    = pix + PIX_W'(1);
            pix_lo_n = 1'b0;
          end
        end
      end
      DONE: begin
        busy_n  = 1'b0;
        state_n = HOLD;
      end
      HOLD: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  cell_painter_lcd_byte_writer u_lcd_byte_writer (
    .clk       (clk),
    .rst       (rst),
    .start     (start_c),
    .dcx       (dcx_c),
    .data      (data_c),
    .lcd_wr_n  (lcd_wr_n),
    .lcd_dcx   (lcd_dcx),
    .lcd_data  (lcd_data),
    .byte_done (byte_done)
  );

endmodule

// File: tb/tb_cell_painter.sv
// Randomised self-checking bench for cell_painter: bytes latched on wr_n
// rising edges are compared with a stream built from the tile rules.
module tb_cell_painter;

  logic       clk = 1'b0;
  logic       rst;
  logic       diff;
  logic [3:0] x;
  logic [3:0] y;
  logic [2:0] obj_code;
  logic       cmd_done;
  logic       busy;
  logic       lcd_wr_n;
  logic       lcd_dcx;
  logic [7:0] lcd_data;

  int n_checks = 0;
  int n_fail   = 0;
  int falls    = 0;
  logic prev_wr = 1'b1;
  logic [8:0] obs_q[$];
  logic [8:0] exp_q[$];

  cell_painter dut (
    .clk      (clk),
    .rst      (rst),
    .diff     (diff),
    .x        (x),
    .y        (y),
    .obj_code (obj_code),
    .cmd_done (cmd_done),
    .busy     (busy),
    .lcd_wr_n (lcd_wr_n),
    .lcd_dcx  (lcd_dcx),
    .lcd_data (lcd_data)
  );

  always #5 clk = ~clk;

  // Panel model: latch {dcx, data} on every wr_n rising edge.
  always @(negedge clk) begin
    if (prev_wr === 1'b1 && lcd_wr_n === 1'b0) falls++;
    if (prev_wr === 1'b0 && lcd_wr_n === 1'b1) obs_q.push_back({lcd_dcx, lcd_data});
    prev_wr = lcd_wr_n;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic int colour_of(input int o);
    case (o)
      0:       return 'h0000;
      1:       return 'h07E0;
      2:       return 'hFFE0;
      3:       return 'hF800;
      4:       return 'h001F;
      default: return 'hF81F;
    endcase
  endfunction

  function automatic void push_word(input int w);
    exp_q.push_back({1'b1, 8'((w >> 8) & 255)});
    exp_q.push_back({1'b1, 8'(w & 255)});
  endfunction

  function automatic void build_expected(input int cx, input int cy, input int co);
    int c;
    exp_q.delete();
    if (cy >= 12) return;
    exp_q.push_back({1'b0, 8'h2A});
    push_word(cx * 20);
    push_word(cx * 20 + 19);
    exp_q.push_back({1'b0, 8'h2B});
    push_word(cy * 20);
    push_word(cy * 20 + 19);
    exp_q.push_back({1'b0, 8'h2C});
    c = colour_of(co);
    for (int i = 0; i < 400; i++) push_word(c);
  endfunction

  // mode 0: diff dropped after accept; mode 1: diff toggled, then held high into HOLD/IDLE.
  task automatic do_req(input logic [3:0] cx, input logic [3:0] cy, input logic [2:0] co,
                        input int mode);
    int cyc;
    int done_at;
    int busy_bad;
    int exp_done;
    int f0;
    int nf0;
    build_expected(int'(cx), int'(cy), int'(co));
    exp_done = (cy >= 4'd12) ? 1 : 1623;
    obs_q.delete();
    f0 = falls;
    x = cx; y = cy; obj_code = co; diff = 1'b1;
    @(posedge clk); #1;
    cyc = 1; done_at = 0; busy_bad = 0;
    while (done_at == 0 && cyc <= 3000) begin
      if (mode == 0) diff = 1'b0;
      else diff = (cyc < 1500) ? 1'($urandom_range(0, 1)) : 1'b1;
      x = 4'($urandom);
      y = 4'($urandom);
      obj_code = 3'($urandom);
      if (busy !== 1'b1) busy_bad++;
      if (cmd_done === 1'b1) done_at = cyc;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    diff = (mode != 0);
    check("done_cycle", 64'(done_at), 64'(exp_done));
    check("busy_window", 64'(busy_bad), 64'd0);
    @(posedge clk); #1;
    check("hold_cmd_done", 64'(cmd_done), 64'd0);
    check("hold_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_wr_n", 64'(lcd_wr_n), 64'd1);
    check("byte_count", 64'(obs_q.size()), 64'(exp_q.size()));
    if (cy >= 4'd12) check("reject_falls", 64'(falls - f0), 64'd0);
    nf0 = n_fail;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check($sformatf("byte%0d", i), 64'(obs_q[i]), 64'(exp_q[i]));
      if (n_fail != nf0) break;
    end
  endtask

  initial begin
    int viol;
    int f0;
    int mode;
    rst = 1'b1; diff = 1'b0; x = '0; y = '0; obj_code = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_n", 64'(lcd_wr_n), 64'd1);
    check("rst_dcx", 64'(lcd_dcx), 64'd1);
    check("rst_data", 64'(lcd_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_cmd_done", 64'(cmd_done), 64'd0);
    rst = 1'b0;

    viol = 0; f0 = falls;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (lcd_wr_n !== 1'b1 || busy !== 1'b0 || cmd_done !== 1'b0) viol++;
    end
    check("idle_outputs", 64'(viol), 64'd0);
    check("idle_falls", 64'(falls - f0), 64'd0);

    do_req(4'd4, 4'd4, 3'd2, 0);
    do_req(4'd15, 4'd11, 3'd4, 0);
    do_req(4'd3, 4'd13, 3'd0, 0);
    do_req(4'd7, 4'd2, 3'd1, 1);
    do_req(4'd9, 4'd0, 3'd3, 1);
    do_req(4'd0, 4'd0, 3'd5, 0);

    // Reset in the middle of the pixel stream.
    obs_q.delete();
    x = 4'd2; y = 4'd5; obj_code = 3'd1; diff = 1'b1;
    @(posedge clk); #1;
    diff = 1'b0;
    for (int i = 0; i < 1000 && obs_q.size() < 300; i++) begin
      @(posedge clk); #1;
    end
    check("reached_byte300", 64'(obs_q.size()), 64'd300);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_wr_n", 64'(lcd_wr_n), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_cmd_done", 64'(cmd_done), 64'd0);
    viol = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (cmd_done !== 1'b0 || busy !== 1'b0) viol++;
    end
    check("post_rst_quiet", 64'(viol), 64'd0);
    do_req(4'd6, 4'd8, 3'd0, 0);

    for (int k = 0; k < 5; k++) begin
      mode = (k == 4) ? 0 : int'($urandom_range(0, 1));
      do_req(4'($urandom), 4'($urandom), 3'($urandom), mode);
    end

    // rst and diff together: reset must win.
    rst = 1'b1; diff = 1'b1; x = 4'd1; y = 4'd1; obj_code = 3'd1;
    @(posedge clk); #1;
    rst = 1'b0; diff = 1'b0;
    check("rst_diff_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    check("rst_diff_busy2", 64'(busy), 64'd0);
    check("rst_diff_wr_n", 64'(lcd_wr_n), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
